// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: Y86-64 memory-stage controller that issues one data-memory request
// per accepted start, with address range checking and a bounded wait for acknowledge.
module mem_access_ctrl #(
    parameter int MEM_WORDS = 1024,
    parameter int TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    input  logic        mem_err,
    output logic        busy,
    output logic        done,
    output logic [63:0] valM,
    output logic        dmem_error,
    output logic        func_error
);
    localparam int          CW    = $clog2(TIMEOUT + 1);
    localparam logic [63:0] LIMIT = 64'(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] wait_cnt;
    logic          is_wr, is_rd, is_inv, in_range;
    logic          accept, issue, ack, expire;
    logic [63:0]   op_addr, op_data;

    always_comb begin
        is_wr    = icode == 4'h4 || icode == 4'h8 || icode == 4'hA;
        is_rd    = icode == 4'h5 || icode == 4'h9 || icode == 4'hB;
        is_inv   = icode >= 4'hC;
        // ret and popq address through the stack pointer in valA
        op_addr  = (icode == 4'h9 || icode == 4'hB) ? valA : valE;
        op_data  = icode == 4'h8 ? valP : valA;
        in_range = op_addr < LIMIT;
        accept   = state == IDLE && start;
        issue    = accept && (is_wr || is_rd) && in_range;
        ack      = state == REQ && mem_ack;
        expire   = state == REQ && !mem_ack && wait_cnt == CW'(TIMEOUT - 1);
        state_n  = state == IDLE ? (accept ? (issue ? REQ : DONE) : IDLE) :
                   state == REQ  ? ((ack || expire) ? DONE : REQ) : IDLE;
    end

    assign mem_req = state == REQ;
    assign busy    = state != IDLE;
    assign done    = state == DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt   <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            valM       <= '0;
            dmem_error <= 1'b0;
            func_error <= 1'b0;
        end else begin
            if (accept) begin
                dmem_error <= (is_wr || is_rd) && !in_range;
                func_error <= is_inv;
            end
            if (issue) begin
                mem_we    <= is_wr;
                mem_addr  <= op_addr;
                mem_wdata <= op_data;
                wait_cnt  <= '0;
            end else if (state == REQ && !mem_ack) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            // an ack in the final wait cycle takes priority over the timeout
            if ((ack && mem_err) || expire) dmem_error <= 1'b1;
            if (ack && !mem_err && !mem_we) valM <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed stimulus with queued expectations checked by a monitor.
module tb_mem_access_ctrl;
    localparam int TIMEOUT = 15;

    typedef struct {logic we; logic [63:0] addr; logic [63:0] wdata; int len;} req_t;
    typedef struct {logic de; logic fe; logic [63:0] vm; int lat;} done_t;

    logic        clk = 0, rst = 1, start = 0, mem_ack = 0, mem_err = 0;
    logic [3:0]  icode = 0;
    logic [63:0] valA = 0, valE = 0, valP = 0, mem_rdata = 0;
    logic        mem_req, mem_we, busy, done, dmem_error, func_error;
    logic [63:0] mem_addr, mem_wdata, valM;

    int total = 0, bad = 0, cyc = 0, start_cyc = 0, run_len = 0;
    logic req_prev = 0;
    req_t  exp_req_q[$];
    done_t exp_done_q[$];
    req_t  cur;
    done_t d;

    mem_access_ctrl #(.MEM_WORDS(1024), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .icode(icode),
        .valA(valA), .valE(valE), .valP(valP),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .busy(busy), .done(done), .valM(valM),
        .dmem_error(dmem_error), .func_error(func_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_req && !req_prev) begin
            if (exp_req_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexp_req: got mem_req=1 addr=%0h want no request", mem_addr);
                cur = '{1'b0, 64'd0, 64'd0, 0};
            end else begin
                cur = exp_req_q.pop_front();
                chk("req_we", mem_we, cur.we);
                chk("req_addr", mem_addr, cur.addr);
                if (cur.we) chk("req_wdata", mem_wdata, cur.wdata);
            end
            run_len = 1;
        end else if (mem_req) begin
            run_len++;
        end else if (req_prev) begin
            chk("req_len", 64'(run_len), 64'(cur.len));
        end
        req_prev = mem_req;
        if (done) begin
            chk("req_in_done", mem_req, 0);
            if (exp_done_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexp_done: got done=1 want none");
            end else begin
                d = exp_done_q.pop_front();
                chk("dmem_error", dmem_error, d.de);
                chk("func_error", func_error, d.fe);
                chk("valM", valM, d.vm);
                chk("latency", 64'(cyc - start_cyc), 64'(d.lat));
            end
        end
    end

    task automatic run(input logic [3:0] ic, input logic [63:0] a, e, p,
                       input int ack_k, input logic [63:0] rd, input logic er, input logic poke,
                       input logic xreq, xwe, input logic [63:0] xaddr, xwdata, input int xlen,
                       input logic xde, xfe, input logic [63:0] xvm, input int xlat);
        int n;
        if (xreq) exp_req_q.push_back('{xwe, xaddr, xwdata, xlen});
        exp_done_q.push_back('{xde, xfe, xvm, xlat});
        @(negedge clk);
        icode = ic; valA = a; valE = e; valP = p; start = 1; start_cyc = cyc;
        @(negedge clk);
        start = 0;
        if (xreq) begin
            for (int k = 1; k <= TIMEOUT; k++) begin
                mem_ack = (k == ack_k); mem_rdata = rd; mem_err = er;
                start = poke; icode = 4'h6;
                @(negedge clk);
                mem_ack = 0;
                if (k == ack_k) break;
            end
            start = 0; mem_err = 0;
        end
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++; bad++;
            $display("FAIL busy_timeout: got busy=1 want 0 within 40 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valM", valM, 0);
        rst = 0;
        // mrmovq, ack in third request cycle
        run(4'h5, 0, 16, 0, 3, 64'hDEAD, 0, 0, 1, 0, 16, 0, 3, 0, 0, 64'hDEAD, 4);
        // pushq, immediate ack
        run(4'hA, 64'h55, 1000, 0, 1, 0, 0, 0, 1, 1, 1000, 64'h55, 1, 0, 0, 64'hDEAD, 2);
        // rmmovq out of range
        run(4'h4, 0, 1024, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 64'hDEAD, 1);
        @(negedge clk);
        chk("dmem_err_held", dmem_error, 1);
        // ret at last legal word
        run(4'h9, 1023, 0, 0, 2, 64'h77, 0, 0, 1, 0, 1023, 0, 2, 0, 0, 64'h77, 3);
        run(4'hD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h77, 1);
        run(4'h6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h77, 1);
        // popq with no ack times out
        run(4'hB, 100, 0, 0, 0, 0, 0, 0, 1, 0, 100, 0, 15, 1, 0, 64'h77, 16);
        // popq with ack in the final wait cycle
        run(4'hB, 200, 0, 0, 15, 64'h1234, 0, 0, 1, 0, 200, 0, 15, 0, 0, 64'h1234, 16);
        // huge address must compare unsigned
        run(4'h5, 0, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 64'h1234, 1);
        // memory fault leaves valM alone
        run(4'h5, 0, 8, 0, 2, 64'h999, 1, 0, 1, 0, 8, 0, 2, 1, 0, 64'h1234, 3);
        // call with extra start pulses during the request
        run(4'h8, 0, 0, 64'h40, 3, 0, 0, 1, 1, 1, 0, 64'h40, 3, 0, 0, 64'h1234, 4);
        // stray ack while idle
        @(negedge clk);
        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0;
        chk("idle_ack_busy", busy, 0);
        // reset in the third request cycle
        exp_req_q.push_back('{1'b0, 64'd300, 64'd0, 3});
        @(negedge clk);
        icode = 4'hB; valA = 300; start = 1; start_cyc = cyc;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("rst_mid_req", mem_req, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valM", valM, 0);
        @(negedge clk);
        rst = 0;
        run(4'h8, 0, 8, 64'h40, 2, 0, 0, 0, 1, 1, 8, 64'h40, 2, 0, 0, 64'h0, 3);
        repeat (3) @(negedge clk);
        chk("req_q_empty", 64'(exp_req_q.size()), 0);
        chk("done_q_empty", 64'(exp_done_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
